datapath_pipe: RTL and testbench
================================

# datapath_pipe

Parametrised two-stage successor to the 4-bit single-cycle datapath. It takes one control word per cycle and reads two operands from an NREG×W register file. It executes one of 16 function-unit operations, registers the result and status flags, and writes back one cycle later. Forwarding hides the write-back latency. It sits between the control unit (which supplies CW, CN and CW_VALID) and the data memory (ADDR_OUT, DATA_OUT, MEM_VALID, DATA_IN).

## Interface
Parameters:
- W, 8: data width. Legal range is ≥ 2.
- NREG, 8: register count. Must be a power of 2 and ≥ 2. AW = log2(NREG).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CW_VALID  in  1  CW is accepted on this edge.
- CW  in  3·AW+8  control word. Bit fields:
  - LF[0]: load flags.
  - RW[1]: register write.
  - MD[2]: write-back select (0 = F, 1 = DATA_IN).
  - FS[6:3]: function select.
  - MB[7]: B-operand select (0 = register, 1 = CN).
  - BA[7+AW:8], AA[7+2AW:8+AW], DA[7+3AW:8+2AW]: B-read, A-read and destination register addresses.
- CN  in  W  constant operand.
- DATA_IN  in  W  memory read data, sampled in the write-back cycle.
- ADDR_OUT  out  W  registered A operand.
- DATA_OUT  out  W  registered B-mux operand.
- MEM_VALID  out  1  ADDR_OUT/DATA_OUT belong to an accepted word.
- FLAGS  out  4  registered {V,C,N,Z}.
- REGS  out  NREG·W  flat register dump; R0 occupies the LSBs.

## Operation
- **Stage EX (accept edge t).**
  - Read ports A=R[AA] and B=R[BA], both forwarded (see below).
  - Bm = MB ? CN : B.
  - F = fu(A, Bm, FS).
  - Load the EX/WB register with {F, DA, MD, RW, valid}.
  - ADDR_OUT←A, DATA_OUT←Bm, MEM_VALID←1.
  - If LF, FLAGS←fu flags.
  - With CW_VALID=0: valid←0, MEM_VALID←0; ADDR_OUT, DATA_OUT and FLAGS hold.
- **Stage WB (cycle t+1, write on edge t+1).**
  - D = MD ? DATA_IN : F.
  - If valid and RW: R[DA]←D.
- **Forwarding.** If WB is valid, RW=1 and DA equals the read address, that read port returns D instead of the register contents. It applies independently to A and B.
- **FS encoding, (W+1)-bit sum for arithmetic, C = carry out:**
  - 0 A
  - 1 A+1
  - 2 A+Bm
  - 3 A+Bm+1
  - 4 A+~Bm
  - 5 A+~Bm+1
  - 6 A−1 (computed as A+all-ones)
  - 7 A
  - 8 A&Bm
  - 9 A|Bm
  - 10 A^Bm
  - 11 ~A
  - 12 Bm
  - 13 Bm>>1 (C = Bm[0])
  - 14 Bm<<1 (C = Bm[W−1])
  - 15 Bm
- **Flags.**
  - Z = (F==0).
  - N = F[W−1].
  - V = two's-complement overflow, only for FS 1–6.
  - C and V are 0 for pass-through and logic ops; V is 0 for shifts.
- No hazards other than the one forwarded path. Write-back at t+1 and read at t+1 resolve through forwarding.
- A write to the same register from two consecutive words: the later one wins, one cycle later.

## Timing
- **Reset (RST_N low, asynchronous).** Applies immediately:
  - all registers = 0, REGS = 0;
  - FLAGS = 0, ADDR_OUT = 0, DATA_OUT = 0, MEM_VALID = 0;
  - EX/WB valid = 0.
- **Reset mid-operation.** A word in WB when reset asserts is discarded with no write. After RST_N rises, the first CW_VALID edge is a normal accept.
- **Latency.**
  - Accept edge t → ADDR_OUT, DATA_OUT, MEM_VALID and FLAGS valid after edge t.
  - REGS reflect the write after edge t+1.
  - A dependent word accepted at edge t+1 sees the new value through forwarding.
- **Memory read timing.** DATA_IN must be stable in the cycle after MEM_VALID is high, before the next edge. It is ignored when MD=0.
- **Throughput.** One word per cycle, with no stall or back-pressure.

## Structure
- Package dp_pkg holds:
  - FS encodings as named localparams (FS_PASSA … FS_SHL);
  - CW field offset functions of AW;
  - the flag bit indices.
- Sub-module func_unit_p (parameter W) is purely combinational: A, Bm, FS → F, C, V. N and Z are derived in the parent.
- The register file, forwarding muxes and EX/WB register live in datapath_pipe.

## Test plan
All scenarios use W=8, NREG=8.

1. **Constant load.** After reset, issue DA=1, MB=1, FS=12, CN=0x5A, RW=1 → R1=0x5A after 2 edges; MEM_VALID=1 for 1 cycle, DATA_OUT=0x5A.
2. **Forwarding.** Issue back-to-back words, each R1=0x5A beforehand:
   - R2←CN 0x01, then R3←R1+R2 (FS=2) on the next edge → R3=0x5B.
   - R3←R3+R3 in consecutive cycles from R3=0x01 → 0x02, then 0x04.
3. **Flags.** R1=0x80, FS=5, MB=1, CN=0x01, LF=1 → F=0x7F, FLAGS V=1, C=1, N=0, Z=0. A following word with LF=0 leaves FLAGS unchanged. FS=10 with R1^R1 → Z=1, C=0, V=0.
4. **Memory load.** MD=1, DA=4, AA=1 (R1=0x20) → ADDR_OUT=0x20. Drive DATA_IN=0xC3 in the next cycle → R4=0xC3. With RW=0 → no register change.
5. **Shifts.** MB=1, CN=0x81, FS=13 → F=0x40, C=1. FS=14 → F=0x02, C=1, V=0.
6. **Reset mid-operation.** Assert RST_N=0 while R5←0x77 is in WB → R5 stays 0. All outputs are 0 immediately, while CLK is still running.

Source files
------------

// File: rtl/dp_pkg.sv
// dp_pkg: shared function-select codes, control-word field layout and flag indices
// for the pipelined datapath.
package dp_pkg;
    localparam logic [3:0] FS_PASSA  = 4'd0;
    localparam logic [3:0] FS_INC    = 4'd1;
    localparam logic [3:0] FS_ADD    = 4'd2;
    localparam logic [3:0] FS_ADDC   = 4'd3;
    localparam logic [3:0] FS_SUBB   = 4'd4;
    localparam logic [3:0] FS_SUB    = 4'd5;
    localparam logic [3:0] FS_DEC    = 4'd6;
    localparam logic [3:0] FS_PASSA2 = 4'd7;
    localparam logic [3:0] FS_AND    = 4'd8;
    localparam logic [3:0] FS_OR     = 4'd9;
    localparam logic [3:0] FS_XOR    = 4'd10;
    localparam logic [3:0] FS_NOT    = 4'd11;
    localparam logic [3:0] FS_PASSB  = 4'd12;
    localparam logic [3:0] FS_SHR    = 4'd13;
    localparam logic [3:0] FS_SHL    = 4'd14;
    localparam logic [3:0] FS_PASSB2 = 4'd15;

    localparam int CW_LF = 0;
    localparam int CW_RW = 1;
    localparam int CW_MD = 2;
    localparam int CW_FS = 3;
    localparam int CW_MB = 7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    function automatic int cw_ba(input int aw);
        return 8;
    endfunction

    function automatic int cw_aa(input int aw);
        return 8 + aw;
    endfunction

    function automatic int cw_da(input int aw);
        return 8 + 2 * aw;
    endfunction

    function automatic int cw_width(input int aw);
        return 8 + 3 * aw;
    endfunction
endpackage

// File: rtl/func_unit_p.sv
// func_unit_p: combinational function unit; produces F, carry and overflow.
// Every arithmetic op is A + y + cin over W+1 bits so one adder serves them all.
module func_unit_p
    import dp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   fs_i,
    output logic [W-1:0] f_o,
    output logic         c_o,
    output logic         v_o
);
    logic [W-1:0] y;
    logic         cin;
    logic [W:0]   sum;

    always_comb begin
        y   = '0;
        cin = 1'b0;
        case (fs_i)
            FS_INC:  cin = 1'b1;
            FS_ADD:  y = b_i;
            FS_ADDC: begin y = b_i; cin = 1'b1; end
            FS_SUBB: y = ~b_i;
            FS_SUB:  begin y = ~b_i; cin = 1'b1; end
            FS_DEC:  y = '1;
            default: ;
        endcase
        sum = {1'b0, a_i} + {1'b0, y} + {{W{1'b0}}, cin};
        f_o = a_i;
        c_o = 1'b0;
        v_o = 1'b0;
        case (fs_i)
            FS_INC, FS_ADD, FS_ADDC, FS_SUBB, FS_SUB, FS_DEC: begin
                f_o = sum[W-1:0];
                c_o = sum[W];
                v_o = (a_i[W-1] == y[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            FS_AND:              f_o = a_i & b_i;
            FS_OR:               f_o = a_i | b_i;
            FS_XOR:              f_o = a_i ^ b_i;
            FS_NOT:              f_o = ~a_i;
            FS_PASSB, FS_PASSB2: f_o = b_i;
            FS_SHR: begin
                f_o = {1'b0, b_i[W-1:1]};
                c_o = b_i[0];
            end
            FS_SHL: begin
                f_o = {b_i[W-2:0], 1'b0};
                c_o = b_i[W-1];
            end
            default:             f_o = a_i;
        endcase
    end
endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage (EX, WB) datapath with an NREG x W register file.
// The WB result is forwarded into both read ports, so back-to-back dependent words never stall.
module datapath_pipe
    import dp_pkg::*;
#(
    parameter int  W    = 8,
    parameter int  NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CW_VALID,
    input  logic [3*AW+7:0]       CW,
    input  logic [W-1:0]          CN,
    input  logic [W-1:0]          DATA_IN,
    output logic [W-1:0]          ADDR_OUT,
    output logic [W-1:0]          DATA_OUT,
    output logic                  MEM_VALID,
    output logic [3:0]            FLAGS,
    output logic [NREG*W-1:0]     REGS
);
    localparam int BA_LO = cw_ba(AW);
    localparam int AA_LO = cw_aa(AW);
    localparam int DA_LO = cw_da(AW);

    logic [W-1:0]  rf_q [NREG];
    logic [W-1:0]  wb_f_q;
    logic [AW-1:0] wb_da_q;
    logic          wb_md_q, wb_rw_q, wb_v_q;
    logic [W-1:0]  addr_q, data_q;
    logic          mv_q;
    logic [3:0]    flags_q, flags_d;

    logic [AW-1:0] aa, ba, da;
    logic [W-1:0]  wb_d, a, b, bm, f;
    logic          we, c, v;

    assign aa = CW[AA_LO +: AW];
    assign ba = CW[BA_LO +: AW];
    assign da = CW[DA_LO +: AW];

    assign wb_d = wb_md_q ? DATA_IN : wb_f_q;
    assign we   = wb_v_q && wb_rw_q;
    assign a    = (we && wb_da_q == aa) ? wb_d : rf_q[aa];
    assign b    = (we && wb_da_q == ba) ? wb_d : rf_q[ba];
    assign bm   = CW[CW_MB] ? CN : b;

    func_unit_p #(.W(W)) u_fu (
        .a_i (a),
        .b_i (bm),
        .fs_i(CW[CW_FS +: 4]),
        .f_o (f),
        .c_o (c),
        .v_o (v)
    );

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_Z] = (f == '0);
        flags_d[FLAG_N] = f[W-1];
        flags_d[FLAG_C] = c;
        flags_d[FLAG_V] = v;
    end

    // Reset drops any word sitting in WB, so its write never lands.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            wb_f_q  <= '0;
            wb_da_q <= '0;
            wb_md_q <= 1'b0;
            wb_rw_q <= 1'b0;
            wb_v_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mv_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            if (we) rf_q[wb_da_q] <= wb_d;
            wb_v_q <= CW_VALID;
            mv_q   <= CW_VALID;
            if (CW_VALID) begin
                wb_f_q  <= f;
                wb_da_q <= da;
                wb_md_q <= CW[CW_MD];
                wb_rw_q <= CW[CW_RW];
                addr_q  <= a;
                data_q  <= bm;
                if (CW[CW_LF]) flags_q <= flags_d;
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign REGS[g*W +: W] = rf_q[g];
    end

    assign ADDR_OUT  = addr_q;
    assign DATA_OUT  = data_q;
    assign MEM_VALID = mv_q;
    assign FLAGS     = flags_q;
endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: scoreboard bench for datapath_pipe at W=8, NREG=8.
// Expected EX outputs are queued when a word is driven and checked after its accept edge.
module tb_datapath_pipe;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CW_VALID = 1'b0;
    logic [16:0] CW = '0;
    logic [7:0]  CN = '0;
    logic [7:0]  DATA_IN = '0;
    logic [7:0]  ADDR_OUT, DATA_OUT;
    logic        MEM_VALID;
    logic [3:0]  FLAGS;
    logic [63:0] REGS;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] d;
        logic [3:0] f;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] last_a = '0, last_d = '0;
    logic [3:0] last_f = '0;

    datapath_pipe #(.W(8), .NREG(8)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CW_VALID (CW_VALID),
        .CW       (CW),
        .CN       (CN),
        .DATA_IN  (DATA_IN),
        .ADDR_OUT (ADDR_OUT),
        .DATA_OUT (DATA_OUT),
        .MEM_VALID(MEM_VALID),
        .FLAGS    (FLAGS),
        .REGS     (REGS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input logic [7:0] exp);
        chk($sformatf("R%0d", idx), REGS[idx*8 +: 8], exp);
    endtask

    function automatic logic [16:0] mkcw(input logic lf, rw, md, input logic [3:0] fs,
                                         input logic mb, input logic [2:0] ba, aa, da);
        return {da, aa, ba, mb, fs, md, rw, lf};
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".mv"}, MEM_VALID, 1);
            chk({e.tag, ".addr"}, ADDR_OUT, e.a);
            chk({e.tag, ".data"}, DATA_OUT, e.d);
            chk({e.tag, ".flags"}, FLAGS, e.f);
            last_a = e.a;
            last_d = e.d;
            last_f = e.f;
        end else begin
            chk("idle.mv", MEM_VALID, 0);
            chk("idle.addr", ADDR_OUT, last_a);
            chk("idle.data", DATA_OUT, last_d);
            chk("idle.flags", FLAGS, last_f);
        end
    endtask

    task automatic issue(input string tag, input logic lf, rw, md, input logic [3:0] fs,
                         input logic mb, input logic [2:0] ba, aa, da, input logic [7:0] cn,
                         input logic [7:0] ea, ed, input logic [3:0] ef);
        exp_t e;
        CW = mkcw(lf, rw, md, fs, mb, ba, aa, da);
        CN = cn;
        CW_VALID = 1'b1;
        e.tag = tag;
        e.a = ea;
        e.d = ed;
        e.f = ef;
        sb.push_back(e);
        tick();
    endtask

    task automatic idle();
        CW_VALID = 1'b0;
        tick();
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.regs", REGS, 64'h0);
        chk("rst.flags", FLAGS, 0);
        chk("rst.mv", MEM_VALID, 0);
        chk("rst.addr", ADDR_OUT, 0);
        RST_N = 1'b1;

        // constant load
        issue("ld1", 0, 1, 0, 4'd12, 1, 0, 0, 1, 8'h5A, 8'h00, 8'h5A, 4'h0);
        idle();
        chk_reg(1, 8'h5A);

        // forwarding into B, then A and B together
        issue("ld2", 0, 1, 0, 4'd12, 1, 0, 0, 2, 8'h01, 8'h00, 8'h01, 4'h0);
        issue("add3", 0, 1, 0, 4'd2, 0, 2, 1, 3, 8'h00, 8'h5A, 8'h01, 4'h0);
        idle();
        chk_reg(2, 8'h01);
        chk_reg(3, 8'h5B);
        issue("ld3", 0, 1, 0, 4'd12, 1, 0, 0, 3, 8'h01, 8'h00, 8'h01, 4'h0);
        issue("dbl1", 0, 1, 0, 4'd2, 0, 3, 3, 3, 8'h00, 8'h01, 8'h01, 4'h0);
        issue("dbl2", 0, 1, 0, 4'd2, 0, 3, 3, 3, 8'h00, 8'h02, 8'h02, 4'h0);
        idle();
        chk_reg(3, 8'h04);

        // flags: 0x80 - 1 overflows, LF=0 holds, XOR self gives Z
        issue("ld80", 0, 1, 0, 4'd12, 1, 0, 0, 1, 8'h80, 8'h00, 8'h80, 4'h0);
        issue("sub", 1, 0, 0, 4'd5, 1, 0, 1, 0, 8'h01, 8'h80, 8'h01, 4'b1100);
        issue("nolf", 0, 0, 0, 4'd2, 1, 0, 1, 0, 8'h01, 8'h80, 8'h01, 4'b1100);
        issue("xor", 1, 0, 0, 4'd10, 0, 1, 1, 0, 8'h00, 8'h80, 8'h80, 4'b0001);
        idle();
        chk_reg(1, 8'h80);

        // memory load: DATA_IN presented in the write-back cycle
        issue("ld20", 0, 1, 0, 4'd12, 1, 0, 0, 1, 8'h20, 8'h00, 8'h20, 4'b0001);
        issue("mem", 0, 1, 1, 4'd0, 0, 0, 1, 4, 8'h00, 8'h20, 8'h00, 4'b0001);
        DATA_IN = 8'hC3;
        idle();
        chk_reg(4, 8'hC3);
        issue("memnw", 0, 0, 1, 4'd0, 0, 0, 1, 5, 8'h00, 8'h20, 8'h00, 4'b0001);
        DATA_IN = 8'h11;
        idle();
        chk_reg(5, 8'h00);

        // shifts
        issue("shr", 1, 0, 0, 4'd13, 1, 0, 0, 0, 8'h81, 8'h00, 8'h81, 4'b0100);
        issue("shl", 1, 0, 0, 4'd14, 1, 0, 0, 0, 8'h81, 8'h00, 8'h81, 4'b0100);
        issue("inc7f", 1, 0, 0, 4'd1, 0, 0, 2, 0, 8'h00, 8'h01, 8'h00, 4'b0000);
        idle();
        chk("regs.all", REGS, 64'h0000_00C3_0401_2000);

        // reset while R5 <- 0x77 sits in WB
        issue("ld77", 0, 1, 0, 4'd12, 1, 0, 0, 5, 8'h77, 8'h00, 8'h77, 4'b0000);
        RST_N = 1'b0;
        #1;
        chk("mrst.regs", REGS, 64'h0);
        chk("mrst.mv", MEM_VALID, 0);
        chk("mrst.addr", ADDR_OUT, 0);
        chk("mrst.data", DATA_OUT, 0);
        chk("mrst.flags", FLAGS, 0);
        CW_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("mrst.r5", REGS[47:40], 8'h00);
        RST_N = 1'b1;
        last_a = '0;
        last_d = '0;
        last_f = '0;
        issue("post", 1, 1, 0, 4'd12, 1, 0, 0, 6, 8'h33, 8'h00, 8'h33, 4'b0000);
        idle();
        chk("post.regs", REGS, 64'h0033_0000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
